// File: rtl/pipeline_arbiter.sv
// Round-robin, packet-locked arbiter sharing one valid/ready stream among C_NUM_CHANNELS requesters.
// Define PIPELINE_ARBITER_OUT_REG_EN to drive the RD_* outputs from a one-deep registered slice.
module pipeline_arbiter #(
  parameter int unsigned C_NUM_CHANNELS = 4,
  parameter int unsigned C_WIDTH        = 32,
  parameter int unsigned C_CHAN_WIDTH   = (C_NUM_CHANNELS > 1) ? $clog2(C_NUM_CHANNELS) : 1
) (
  input  logic                              CLK,
  input  logic                              RST_IN,
  input  logic [C_NUM_CHANNELS*C_WIDTH-1:0] WR_DATA,
  input  logic [C_NUM_CHANNELS-1:0]         WR_DATA_VALID,
  input  logic [C_NUM_CHANNELS-1:0]         WR_DATA_LAST,
  output logic [C_NUM_CHANNELS-1:0]         WR_DATA_READY,
  output logic [C_WIDTH-1:0]                RD_DATA,
  output logic                              RD_DATA_VALID,
  output logic                              RD_DATA_LAST,
  output logic [C_CHAN_WIDTH-1:0]           RD_DATA_CHANNEL,
  input  logic                              RD_DATA_READY
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                  r_state;
  logic [C_CHAN_WIDTH-1:0] r_grant;
  logic [C_CHAN_WIDTH-1:0] r_last_grant;

  logic [C_CHAN_WIDTH-1:0] w_base;
  logic [C_CHAN_WIDTH-1:0] w_cand;
  logic [C_CHAN_WIDTH-1:0] w_winner;
  logic                    w_found;
  int unsigned             w_idx;
  logic                    w_busy;
  logic                    w_up_ready;
  logic                    w_gnt_valid;
  logic                    w_gnt_last;
  logic [C_WIDTH-1:0]      w_gnt_data;
  logic                    w_xfer;

  // Round-robin search starting one past the last (IDLE) or current (BUSY) owner.
  always_comb begin
    w_base   = (r_state == S_IDLE) ? r_last_grant : r_grant;
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    w_cand   = '0;
    for (int unsigned k = 1; k <= C_NUM_CHANNELS; k++) begin
      w_idx = 32'(w_base) + k;
      if (w_idx >= C_NUM_CHANNELS) w_idx = w_idx - C_NUM_CHANNELS;
      w_cand = C_CHAN_WIDTH'(w_idx);
      if (!w_found && WR_DATA_VALID[w_cand]) begin
        w_winner = w_cand;
        w_found  = 1'b1;
      end
    end
  end

  assign w_busy      = (r_state == S_BUSY);
  assign w_gnt_valid = WR_DATA_VALID[r_grant];
  assign w_gnt_last  = WR_DATA_LAST[r_grant];
  assign w_gnt_data  = WR_DATA[32'(r_grant)*C_WIDTH +: C_WIDTH];
  assign w_xfer      = w_busy && w_gnt_valid && w_up_ready;

  always_comb begin
    WR_DATA_READY = '0;
    if (w_busy) WR_DATA_READY[r_grant] = w_up_ready;
  end

  // Grant is only re-evaluated in IDLE or on an accepted LAST beat.
  always_ff @(posedge CLK) begin
    if (RST_IN) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= C_CHAN_WIDTH'(C_NUM_CHANNELS - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_winner;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_xfer && w_gnt_last) begin
            r_last_grant <= r_grant;
            if (w_found) r_grant <= w_winner;
            else         r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PIPELINE_ARBITER_OUT_REG_EN
  logic                    r_out_valid;
  logic                    r_out_last;
  logic [C_CHAN_WIDTH-1:0] r_out_chan;
  logic [C_WIDTH-1:0]      r_out_data;

  assign w_up_ready = ~r_out_valid | RD_DATA_READY;

  // Output slice: loads on every accepted beat, empties when downstream takes it.
  always_ff @(posedge CLK) begin
    if (RST_IN) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_chan  <= '0;
      r_out_data  <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_gnt_last;
      r_out_chan  <= r_grant;
      r_out_data  <= w_gnt_data;
    end else if (RD_DATA_READY) begin
      r_out_valid <= 1'b0;
    end
  end

  assign RD_DATA         = r_out_data;
  assign RD_DATA_VALID   = r_out_valid;
  assign RD_DATA_LAST    = r_out_last;
  assign RD_DATA_CHANNEL = r_out_chan;
`else
  assign w_up_ready      = RD_DATA_READY;
  assign RD_DATA         = w_gnt_data;
  assign RD_DATA_VALID   = w_busy & w_gnt_valid;
  assign RD_DATA_LAST    = w_busy & w_gnt_last;
  assign RD_DATA_CHANNEL = r_grant;
`endif

endmodule

// File: tb/tb_pipeline_arbiter.sv
// Self-checking bench for pipeline_arbiter: cycle table plus scoreboarded packet scenarios.
module tb_pipeline_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 2;
`ifdef PIPELINE_ARBITER_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic           CLK = 1'b0;
  logic           RST_IN;
  logic [N*W-1:0] WR_DATA;
  logic [N-1:0]   WR_DATA_VALID;
  logic [N-1:0]   WR_DATA_LAST;
  logic [N-1:0]   WR_DATA_READY;
  logic [W-1:0]   RD_DATA;
  logic           RD_DATA_VALID;
  logic           RD_DATA_LAST;
  logic [CW-1:0]  RD_DATA_CHANNEL;
  logic           RD_DATA_READY;

  pipeline_arbiter #(.C_NUM_CHANNELS(N), .C_WIDTH(W), .C_CHAN_WIDTH(CW)) dut (
    .CLK(CLK), .RST_IN(RST_IN),
    .WR_DATA(WR_DATA), .WR_DATA_VALID(WR_DATA_VALID), .WR_DATA_LAST(WR_DATA_LAST),
    .WR_DATA_READY(WR_DATA_READY),
    .RD_DATA(RD_DATA), .RD_DATA_VALID(RD_DATA_VALID), .RD_DATA_LAST(RD_DATA_LAST),
    .RD_DATA_CHANNEL(RD_DATA_CHANNEL), .RD_DATA_READY(RD_DATA_READY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [W-1:0] data; logic last; } beat_t;
  typedef struct packed { logic [W-1:0] data; logic last; logic [CW-1:0] chan; } exp_t;
  typedef struct packed {
    logic [N-1:0] v; logic [N-1:0] l; logic rdy;
    logic [N-1:0] e_wr; logic e_val; logic [CW-1:0] e_ch; logic e_last;
  } vec_t;

  beat_t stim_q[N][$];
  exp_t  exp_q[$];
  vec_t  tbl[14];

  int n_vec = 0;
  int n_err = 0;
  int cyc, first_cyc, last_cyc, n_beats, ready_viol;
  bit rand_rdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] bdata(input int ch, input int b, input int tag);
    return {8'(tag), 8'(ch), 16'(b)};
  endfunction

  task automatic drive();
    WR_DATA_VALID = '0;
    WR_DATA_LAST  = '0;
    WR_DATA       = '0;
    for (int i = 0; i < N; i++) begin
      if (stim_q[i].size() > 0) begin
        WR_DATA_VALID[i]  = 1'b1;
        WR_DATA_LAST[i]   = stim_q[i][0].last;
        WR_DATA[i*W +: W] = stim_q[i][0].data;
      end
    end
    RD_DATA_READY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // Queue a packet and its expected output beats, in the order the bench predicts.
  task automatic send(input int ch, input int nb, input int tag);
    for (int b = 0; b < nb; b++) begin
      beat_t s;
      exp_t  e;
      s.data = bdata(ch, b, tag);
      s.last = (b == nb - 1);
      stim_q[ch].push_back(s);
      e.data = s.data;
      e.last = s.last;
      e.chan = CW'(ch);
      exp_q.push_back(e);
    end
  endtask

  task automatic cycle();
    logic [N-1:0] taken;
    exp_t e;
    @(negedge CLK);
    taken = WR_DATA_VALID & WR_DATA_READY;
    if (stim_q[1].size() > 0 && WR_DATA_READY[0]) ready_viol++;
    if (RD_DATA_VALID && RD_DATA_READY) begin
      n_beats++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat: got ch %0d data %0h, expected no beat", RD_DATA_CHANNEL, RD_DATA);
      end else begin
        e = exp_q.pop_front();
        chk("beat", 64'({RD_DATA_CHANNEL, RD_DATA_LAST, RD_DATA}), 64'({e.chan, e.last, e.data}));
      end
    end
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++) if (taken[i]) void'(stim_q[i].pop_front());
    drive();
    cyc++;
  endtask

  task automatic run(input int budget);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      cycle();
      k++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d beats pending, expected 0", exp_q.size());
    end
  endtask

  task automatic clear_counts();
    cyc = 0; first_cyc = -1; last_cyc = -1; n_beats = 0; ready_viol = 0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) stim_q[i].delete();
    exp_q.delete();
    rand_rdy = 1'b0;
    RST_IN = 1'b1;
    drive();
    repeat (2) @(posedge CLK);
    #1;
    RST_IN = 1'b0;
    @(negedge CLK);
    chk("rst_rd_valid", 64'(RD_DATA_VALID), 64'd0);
    chk("rst_wr_ready", 64'(WR_DATA_READY), 64'd0);
    chk("rst_rd_last",  64'(RD_DATA_LAST), 64'd0);
    chk("rst_rd_chan",  64'(RD_DATA_CHANNEL), 64'd0);
    @(posedge CLK);
    #1;
    clear_counts();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // v, l, rdy, e_wr, e_val, e_ch, e_last
    tbl[0]  = '{4'b1000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0};
    tbl[2]  = '{4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b0};
    tbl[3]  = '{4'b1001, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0};
    tbl[4]  = '{4'b1001, 4'b1000, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b1};
    tbl[5]  = '{4'b1001, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
    tbl[6]  = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    tbl[7]  = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0};
    tbl[8]  = '{4'b0110, 4'b0110, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0};
    tbl[9]  = '{4'b0111, 4'b0111, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1};
    tbl[10] = '{4'b0111, 4'b0111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    tbl[11] = '{4'b0110, 4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    tbl[12] = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    tbl[13] = '{4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b0};

    do_reset();

`ifndef PIPELINE_ARBITER_OUT_REG_EN
    // Cycle-exact pass-through behaviour: ready mirroring, hold, handoff, wrap.
    for (int i = 0; i < N; i++) WR_DATA[i*W +: W] = 32'hC0DE_0000 | 32'(i);
    for (int t = 0; t < 14; t++) begin
      WR_DATA_VALID = tbl[t].v;
      WR_DATA_LAST  = tbl[t].l;
      RD_DATA_READY = tbl[t].rdy;
      @(negedge CLK);
      chk($sformatf("tbl%0d_wr_ready", t), 64'(WR_DATA_READY), 64'(tbl[t].e_wr));
      chk($sformatf("tbl%0d_rd_valid", t), 64'(RD_DATA_VALID), 64'(tbl[t].e_val));
      chk($sformatf("tbl%0d_rd_chan", t),  64'(RD_DATA_CHANNEL), 64'(tbl[t].e_ch));
      chk($sformatf("tbl%0d_rd_last", t),  64'(RD_DATA_LAST), 64'(tbl[t].e_last));
      if (tbl[t].e_val)
        chk($sformatf("tbl%0d_rd_data", t), 64'(RD_DATA), 64'(32'hC0DE_0000 | 32'(tbl[t].e_ch)));
      @(posedge CLK);
      #1;
    end
    do_reset();
`endif

    // Lone 3-beat packet on channel 2: one arbitration bubble, then back-to-back beats.
    send(2, 3, 1);
    drive();
    run(50);
    chk("s1_first_cycle", 64'(first_cyc), 64'(LAT));
    chk("s1_burst_span",  64'(last_cyc - first_cyc), 64'd2);
    chk("s1_beats",       64'(n_beats), 64'd3);

    // All channels with single-beat packets: strict 0,1,2,3 rotation, no gaps.
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < N; c++) send(c, 1, 2 + r);
    drive();
    run(80);
    chk("s2_first_cycle", 64'(first_cyc), 64'(LAT));
    chk("s2_span",        64'(last_cyc - first_cyc), 64'd11);
    chk("s2_beats",       64'(n_beats), 64'd12);

    // Channel 1 holds a 4-beat packet while channel 0 waits, then zero-bubble handoff.
    do_reset();
    send(1, 4, 5);
    drive();
    cycle();
    cycle();
    send(0, 1, 6);
    drive();
    run(50);
    chk("s3_ch0_no_ready", 64'(ready_viol), 64'd0);
    chk("s3_span",         64'(last_cyc - first_cyc), 64'd4);
    chk("s3_beats",        64'(n_beats), 64'd5);

    // Reset after two output beats of a 5-beat packet; restart with channels 1 and 2.
    do_reset();
    send(1, 5, 7);
    drive();
    begin
      int k;
      k = 0;
      while (n_beats < 2 && k < 50) begin
        cycle();
        k++;
      end
    end
    chk("s5_beats_before_rst", 64'(n_beats), 64'd2);
    RST_IN = 1'b1;
    @(posedge CLK);
    #1;
    RST_IN = 1'b0;
    for (int i = 0; i < N; i++) stim_q[i].delete();
    exp_q.delete();
    send(1, 2, 8);
    send(2, 2, 8);
    drive();
    clear_counts();
    @(negedge CLK);
    chk("s5_rd_valid_after_rst", 64'(RD_DATA_VALID), 64'd0);
    chk("s5_wr_ready_after_rst", 64'(WR_DATA_READY), 64'd0);
    run(50);
    chk("s5_beats", 64'(n_beats), 64'd4);

    // Mixed packet lengths under random downstream backpressure.
    do_reset();
    rand_rdy = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < N; c++) send(c, c + 1, 9 + r);
    drive();
    run(600);
    chk("s6_beats", 64'(n_beats), 64'd20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
